// File: rtl/ddr5_cmd_issuer_pkg.sv
// Shared definitions for the DDR5 command issuer: command encoding, request
// payload layout, default timing and bank indexing.
package ddr5_cmd_issuer_pkg;

    localparam int unsigned QUEUE_DEPTH_DEF = 16;
    localparam int unsigned T_RCD_DEF       = 39;
    localparam int unsigned T_RP_DEF        = 39;
    localparam int unsigned T_CL_DEF        = 40;
    localparam int unsigned T_CWL_DEF       = 38;
    localparam int unsigned T_BURST_DEF     = 8;

    localparam int unsigned NUM_BANKS = 32;
    localparam int unsigned BANK_W    = 5;

    // Request opcodes; anything other than a write is serviced as a read.
    localparam logic [1:0] OP_READ   = 2'd0;
    localparam logic [1:0] OP_WRITE  = 2'd1;
    localparam logic [1:0] OP_IFETCH = 2'd2;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_PRE = 3'd2,
        CMD_RD  = 3'd3,
        CMD_WR  = 3'd4
    } cmd_e;

    typedef struct packed {
        logic [1:0]  op;
        logic [2:0]  bg;
        logic [1:0]  ba;
        logic [15:0] row;
        logic [9:0]  col;
    } req_t;

    localparam int unsigned REQ_W = $bits(req_t);

    // Flat bank index: bank group in the upper bits, bank in the lower bits.
    function automatic logic [BANK_W-1:0] bank_idx(input logic [2:0] bg, input logic [1:0] ba);
        return {bg, ba};
    endfunction

endpackage

// File: rtl/ddr5_req_fifo.sv
// In-order request buffer.
// Ports: clock/reset (sync, active-high); push/push_data write when not full;
// pop advances head when not empty; head is the oldest entry; full/empty/count
// reflect the registered occupancy.
module ddr5_req_fifo #(
    parameter  int unsigned DEPTH = 16,
    parameter  int unsigned WIDTH = 33,
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage needs no reset; occupancy decides what is valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap explicitly so non-power-of-two depths work.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr5_cmd_issuer.sv
// DDR5 command issuer: buffers mapped requests and issues PRE/ACT/RD/WR for
// them one at a time, in arrival order, with an open-page bank policy.
// Ports: clock/reset (sync, active-high); req_* request handshake and address;
// cmd_* one-cycle command strobe with type and address; done_valid pulses when
// the serviced request's data phase completes; q_count is buffer occupancy.
module ddr5_cmd_issuer
    import ddr5_cmd_issuer_pkg::*;
#(
    parameter int unsigned QUEUE_DEPTH = QUEUE_DEPTH_DEF,
    parameter int unsigned T_RCD       = T_RCD_DEF,
    parameter int unsigned T_RP        = T_RP_DEF,
    parameter int unsigned T_CL        = T_CL_DEF,
    parameter int unsigned T_CWL       = T_CWL_DEF,
    parameter int unsigned T_BURST     = T_BURST_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_op,
    input  logic [2:0]  req_bg,
    input  logic [1:0]  req_ba,
    input  logic [15:0] req_row,
    input  logic [9:0]  req_col,
    output logic        cmd_valid,
    output logic [2:0]  cmd_type,
    output logic [2:0]  cmd_bg,
    output logic [1:0]  cmd_ba,
    output logic [15:0] cmd_row,
    output logic [9:0]  cmd_col,
    output logic        done_valid,
    output logic [4:0]  q_count
);

    localparam int unsigned CW       = $clog2(QUEUE_DEPTH + 1);
    localparam int unsigned RD_LAT   = T_CL + T_BURST;
    localparam int unsigned WR_LAT   = T_CWL + T_BURST;
    localparam int unsigned LAT_MAX  = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int unsigned ACT_MAX  = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int unsigned WAIT_MAX = (LAT_MAX > ACT_MAX) ? LAT_MAX : ACT_MAX;
    localparam int unsigned CNT_W    = $clog2(WAIT_MAX + 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PRE       = 3'd1;
    localparam logic [2:0] S_WAIT_RP   = 3'd2;
    localparam logic [2:0] S_ACT       = 3'd3;
    localparam logic [2:0] S_WAIT_RCD  = 3'd4;
    localparam logic [2:0] S_RW        = 3'd5;
    localparam logic [2:0] S_WAIT_DONE = 3'd6;

    req_t              in_req;
    req_t              head;
    logic [REQ_W-1:0]  head_bits;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CW-1:0]     fifo_count;
    logic [BANK_W-1:0] head_bank;
    logic              head_is_wr;

    logic [2:0]        state;
    logic [2:0]        state_next;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_next;

    logic [NUM_BANKS-1:0] bank_open;
    logic [15:0]          bank_row [NUM_BANKS];

    logic        cmd_valid_next;
    cmd_e        cmd_type_next;
    logic [2:0]  cmd_bg_next;
    logic [1:0]  cmd_ba_next;
    logic [15:0] cmd_row_next;
    logic [9:0]  cmd_col_next;
    logic        done_next;

    assign in_req     = '{op: req_op, bg: req_bg, ba: req_ba, row: req_row, col: req_col};
    assign head       = req_t'(head_bits);
    assign head_bank  = bank_idx(head.bg, head.ba);
    assign head_is_wr = (head.op == OP_WRITE);
    assign req_ready  = !fifo_full;
    assign q_count    = 5'(fifo_count);

    ddr5_req_fifo #(
        .DEPTH (QUEUE_DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (req_valid),
        .push_data (in_req),
        .pop       (state == S_RW),
        .head      (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Next state plus the command belonging to the state being entered, so the
    // registered strobe lines up with the FSM state that issues it.
    always_comb begin
        state_next     = state;
        cnt_next       = cnt;
        done_next      = 1'b0;
        cmd_valid_next = 1'b0;
        cmd_type_next  = CMD_NOP;
        cmd_bg_next    = '0;
        cmd_ba_next    = '0;
        cmd_row_next   = '0;
        cmd_col_next   = '0;

        // Wait counters load N-2: one cycle is the issue state, one the exit.
        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    if (!bank_open[head_bank]) begin
                        state_next = S_ACT;
                    end else if (bank_row[head_bank] == head.row) begin
                        state_next = S_RW;
                    end else begin
                        state_next = S_PRE;
                    end
                end
            end
            S_PRE: begin
                state_next = S_WAIT_RP;
                cnt_next   = CNT_W'(T_RP - 2);
            end
            S_WAIT_RP: begin
                if (cnt == '0) state_next = S_ACT;
                else           cnt_next   = cnt - CNT_W'(1);
            end
            S_ACT: begin
                state_next = S_WAIT_RCD;
                cnt_next   = CNT_W'(T_RCD - 2);
            end
            S_WAIT_RCD: begin
                if (cnt == '0) state_next = S_RW;
                else           cnt_next   = cnt - CNT_W'(1);
            end
            S_RW: begin
                state_next = S_WAIT_DONE;
                cnt_next   = head_is_wr ? CNT_W'(WR_LAT - 2) : CNT_W'(RD_LAT - 2);
            end
            S_WAIT_DONE: begin
                if (cnt == '0) begin
                    state_next = S_IDLE;
                    done_next  = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: state_next = S_IDLE;
        endcase

        case (state_next)
            S_PRE: begin
                cmd_valid_next = 1'b1;
                cmd_type_next  = CMD_PRE;
                cmd_bg_next    = head.bg;
                cmd_ba_next    = head.ba;
            end
            S_ACT: begin
                cmd_valid_next = 1'b1;
                cmd_type_next  = CMD_ACT;
                cmd_bg_next    = head.bg;
                cmd_ba_next    = head.ba;
                cmd_row_next   = head.row;
            end
            S_RW: begin
                cmd_valid_next = 1'b1;
                cmd_type_next  = head_is_wr ? CMD_WR : CMD_RD;
                cmd_bg_next    = head.bg;
                cmd_ba_next    = head.ba;
                cmd_col_next   = head.col;
            end
            default: ;
        endcase
    end

    // FSM state, wait counter and registered command outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            cmd_valid  <= 1'b0;
            cmd_type   <= CMD_NOP;
            cmd_bg     <= '0;
            cmd_ba     <= '0;
            cmd_row    <= '0;
            cmd_col    <= '0;
            done_valid <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            cmd_valid  <= cmd_valid_next;
            cmd_type   <= cmd_type_next;
            cmd_bg     <= cmd_bg_next;
            cmd_ba     <= cmd_ba_next;
            cmd_row    <= cmd_row_next;
            cmd_col    <= cmd_col_next;
            done_valid <= done_next;
        end
    end

    // Bank open flags, updated in the cycle the ACT/PRE is on the bus.
    always_ff @(posedge clock) begin
        if (reset) begin
            bank_open <= '0;
        end else if (state == S_ACT) begin
            bank_open[head_bank] <= 1'b1;
        end else if (state == S_PRE) begin
            bank_open[head_bank] <= 1'b0;
        end
    end

    // Open row per bank; only meaningful while the bank's flag is set.
    always_ff @(posedge clock) begin
        if (state == S_ACT) begin
            bank_row[head_bank] <= head.row;
        end
    end

endmodule

// File: tb/tb_ddr5_cmd_issuer.sv
module tb_ddr5_cmd_issuer;
    import ddr5_cmd_issuer_pkg::*;

    localparam int unsigned TRCD = 39;
    localparam int unsigned TRP  = 39;
    localparam int unsigned RLAT = 48;  // T_CL + T_BURST
    localparam int unsigned WLAT = 46;  // T_CWL + T_BURST

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [2:0]  req_bg = '0;
    logic [1:0]  req_ba = '0;
    logic [15:0] req_row = '0;
    logic [9:0]  req_col = '0;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_ba;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;
    logic        done_valid;
    logic [4:0]  q_count;

    ddr5_cmd_issuer dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_bg     (req_bg),
        .req_ba     (req_ba),
        .req_row    (req_row),
        .req_col    (req_col),
        .cmd_valid  (cmd_valid),
        .cmd_type   (cmd_type),
        .cmd_bg     (cmd_bg),
        .cmd_ba     (cmd_ba),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .done_valid (done_valid),
        .q_count    (q_count)
    );

    always #5 clock = ~clock;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int unsigned at;
        logic [2:0]  typ;
        logic [2:0]  bg;
        logic [1:0]  ba;
        logic [15:0] row;
        logic [9:0]  col;
    } exp_cmd_t;

    exp_cmd_t    exp_cmd [$];
    int unsigned exp_done [$];
    int          checks = 0;
    int          failures = 0;
    int unsigned last_done = 0;

    task automatic check(input string name, input longint got, input longint want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Expected command stream for one request. kind: 0 row hit, 1 bank closed, 2 row conflict.
    task automatic exp_req(input int unsigned e, input logic [1:0] op, input logic [2:0] bg,
                           input logic [1:0] ba, input logic [15:0] row, input logic [9:0] col,
                           input int kind);
        int unsigned t;
        exp_cmd_t    x;
        t = ((e > last_done) ? e : last_done) + 1;
        if (kind == 2) begin
            x = '{t, CMD_PRE, bg, ba, 16'h0, 10'h0};
            exp_cmd.push_back(x);
            t += TRP;
        end
        if (kind >= 1) begin
            x = '{t, CMD_ACT, bg, ba, row, 10'h0};
            exp_cmd.push_back(x);
            t += TRCD;
        end
        x = '{t, (op == OP_WRITE) ? CMD_WR : CMD_RD, bg, ba, row, col};
        exp_cmd.push_back(x);
        t += (op == OP_WRITE) ? WLAT : RLAT;
        exp_done.push_back(t);
        last_done = t;
    endtask

    // Drive one request from a negedge; e is the accepting clock edge.
    task automatic push_req(input logic [1:0] op, input logic [2:0] bg, input logic [1:0] ba,
                            input logic [15:0] row, input logic [9:0] col, output int unsigned e);
        int unsigned waited;
        waited = 0;
        e = 0;
        @(negedge clock);
        req_op = op; req_bg = bg; req_ba = ba; req_row = row; req_col = col;
        req_valid = 1'b1;
        while (!req_ready && waited < 200) begin
            @(negedge clock);
            waited++;
        end
        check("push_accept", req_ready, 1);
        if (req_ready) begin
            e = cyc + 1;
            @(posedge clock);
        end
        #1 req_valid = 1'b0;
    endtask

    task automatic wait_drain(input int unsigned budget);
        int unsigned n;
        n = 0;
        while ((exp_cmd.size() != 0 || exp_done.size() != 0) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("drain_pending", exp_cmd.size() + exp_done.size(), 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_valid"}, cmd_valid, 0);
        check({tag, "_cmd_type"}, cmd_type, CMD_NOP);
        check({tag, "_cmd_addr"}, {cmd_bg, cmd_ba, cmd_row, cmd_col}, 0);
        check({tag, "_done"}, done_valid, 0);
        check({tag, "_q_count"}, q_count, 0);
        check({tag, "_req_ready"}, req_ready, 1);
    endtask

    // Monitor: every output strobe pops and compares the oldest expectation.
    always @(negedge clock) begin : monitor
        exp_cmd_t    x;
        int unsigned d;
        if (!reset) begin
            if (cmd_valid) begin
                if (exp_cmd.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_cmd: got type %0d at cycle %0d expected none", cmd_type, cyc);
                end else begin
                    x = exp_cmd.pop_front();
                    check("cmd_cycle", cyc, x.at);
                    check("cmd_type", cmd_type, x.typ);
                    check("cmd_bg", cmd_bg, x.bg);
                    check("cmd_ba", cmd_ba, x.ba);
                    if (x.typ == CMD_ACT) check("cmd_row", cmd_row, x.row);
                    if (x.typ == CMD_RD || x.typ == CMD_WR) check("cmd_col", cmd_col, x.col);
                end
            end else begin
                check("idle_cmd_nop", cmd_type, CMD_NOP);
            end
            if (done_valid) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: got pulse at cycle %0d expected none", cyc);
                end else begin
                    d = exp_done.pop_front();
                    check("done_cycle", cyc, d);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    initial begin : stim
        int unsigned e;
        int unsigned ea;
        logic [1:0]  op;

        repeat (3) @(posedge clock);
        @(negedge clock);
        check_reset_outputs("reset");
        reset = 1'b0;

        // Read to closed bank 0/0: ACT at t, RD at t+39, done at t+87.
        push_req(OP_READ, 3'd0, 2'd0, 16'h1234, 10'h010, e);
        exp_req(e, OP_READ, 3'd0, 2'd0, 16'h1234, 10'h010, 1);
        wait_drain(300);

        // Same row again: row hit, RD straight out of IDLE.
        push_req(OP_READ, 3'd0, 2'd0, 16'h1234, 10'h020, e);
        exp_req(e, OP_READ, 3'd0, 2'd0, 16'h1234, 10'h020, 0);
        wait_drain(300);

        // Write to a different row in bank 0/0: PRE, ACT, WR, done after 46.
        push_req(OP_WRITE, 3'd0, 2'd0, 16'h5678, 10'h030, e);
        exp_req(e, OP_WRITE, 3'd0, 2'd0, 16'h5678, 10'h030, 2);
        wait_drain(300);

        // 16 back-to-back pushes while the head waits on ACT; the 17th stalls.
        for (int k = 0; k < 16; k++) begin
            op = 2'(k % 3);
            push_req(op, 3'd1, 2'd0, 16'h0001, 10'(k), e);
            exp_req(e, op, 3'd1, 2'd0, 16'h0001, 10'(k), (k == 0) ? 1 : 0);
        end
        @(negedge clock);
        check("full_q_count", q_count, 16);
        check("full_req_ready", req_ready, 0);
        op = 2'(16 % 3);
        push_req(op, 3'd1, 2'd0, 16'h0001, 10'd16, e);
        exp_req(e, op, 3'd1, 2'd0, 16'h0001, 10'd16, 0);
        wait_drain(2000);

        // Five entries queued, sixth push lands on the RW pop edge.
        push_req(OP_READ, 3'd2, 2'd0, 16'h0ABC, 10'd1, ea);
        exp_req(ea, OP_READ, 3'd2, 2'd0, 16'h0ABC, 10'd1, 1);
        for (int k = 2; k <= 5; k++) begin
            op = (k % 2 == 0) ? OP_WRITE : OP_IFETCH;
            push_req(op, 3'd2, 2'd0, 16'h0ABC, 10'(k), e);
            exp_req(e, op, 3'd2, 2'd0, 16'h0ABC, 10'(k), 0);
        end
        while (cyc < ea + 39) @(negedge clock);
        check("pre_pop_q_count", q_count, 5);
        push_req(OP_READ, 3'd2, 2'd0, 16'h0ABC, 10'd6, e);
        exp_req(e, OP_READ, 3'd2, 2'd0, 16'h0ABC, 10'd6, 0);
        @(negedge clock);
        check("push_pop_q_count", q_count, 5);
        wait_drain(1000);

        // Reset during WAIT_RCD abandons the request and closes the bank.
        push_req(OP_READ, 3'd3, 2'd0, 16'h0777, 10'd2, e);
        exp_cmd.push_back('{e + 1, CMD_ACT, 3'd3, 2'd0, 16'h0777, 10'h0});
        while (cyc < e + 10) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("midreset");
        reset = 1'b0;
        last_done = 0;
        check("midreset_pending", exp_cmd.size(), 0);
        repeat (100) @(negedge clock);
        push_req(OP_READ, 3'd3, 2'd0, 16'h0777, 10'd3, e);
        exp_req(e, OP_READ, 3'd3, 2'd0, 16'h0777, 10'd3, 1);
        wait_drain(300);

        repeat (20) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ddr5_cmd_issuer.md
DDR5_CMD_ISSUER -- requirements
Module: ddr5_cmd_issuer

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 16, request buffer entries.
REQ-002 SHALL have parameter T_RCD, default 39, ACT-to-RD/WR delay in clocks.
REQ-003 SHALL have parameter T_RP, default 39, PRE-to-ACT delay in clocks.
REQ-004 SHALL have parameter T_CL, default 40, read latency in clocks.
REQ-005 SHALL have parameter T_CWL, default 38, write latency in clocks.
REQ-006 SHALL have parameter T_BURST, default 8, data burst duration in clocks.
REQ-007 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-008 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-009 SHALL have port req_valid  input  1  mapped request present.
REQ-010 SHALL have port req_ready  output  1  buffer can accept a request (!full).
REQ-011 SHALL have port req_op  input  2  0 data read, 1 data write, 2 instruction fetch (treated as read).
REQ-012 SHALL have ports req_bg/req_ba/req_row/req_col  input  3/2/16/10  mapped bank group, bank, row, column.
REQ-013 SHALL have port cmd_valid  output  1  one-cycle command strobe.
REQ-014 SHALL have port cmd_type  output  3  NOP, ACT, PRE, RD, WR (package enum).
REQ-015 SHALL have ports cmd_bg/cmd_ba/cmd_row/cmd_col  output  3/2/16/10  command address.
REQ-016 SHALL have port done_valid  output  1  one-cycle pulse when head request data phase completes.
REQ-017 SHALL have port q_count  output  5  buffer occupancy.

Function
REQ-018 SHALL accept a request on cycle where req_valid and req_ready are both 1; otherwise request ignored.
REQ-019 SHALL service requests strictly in arrival order, one at a time.
REQ-020 SHALL track per bank (32 = 8 BG x 4 BA) an open flag and open row; open-page policy.
REQ-021 SHALL run FSM states IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, RW, WAIT_DONE.
REQ-022 IDLE with buffer non-empty: row hit -> RW; bank closed -> ACT; row miss -> PRE.
REQ-023 PRE SHALL issue one PRE cycle, clear bank open flag, go to WAIT_RP for T_RP-1 cycles, then ACT.
REQ-024 ACT SHALL issue one ACT cycle, set bank open with row, go to WAIT_RCD for T_RCD-1 cycles, then RW.
REQ-025 RW SHALL issue RD (op 0/2) or WR (op 1) for one cycle and pop the head entry in that cycle.
REQ-026 WAIT_DONE SHALL last T_CL+T_BURST (read) or T_CWL+T_BURST (write) cycles after RW, then pulse done_valid and return to IDLE.
REQ-027 cmd_type SHALL be NOP and cmd_valid 0 in every cycle not issuing a command.
REQ-028 Push and pop in same cycle SHALL leave q_count unchanged; push to full buffer SHALL not occur (req_ready 0).
REQ-029 Request pushed into empty buffer SHALL be seen by FSM no earlier than next cycle.
REQ-030 Buffer pointers SHALL wrap modulo QUEUE_DEPTH; q_count range 0..QUEUE_DEPTH.
REQ-031 Wait counters SHALL be wide enough for max(T_CL,T_CWL)+T_BURST without overflow.

Reset
REQ-032 reset SHALL flush buffer (q_count 0, req_ready 1), close all banks, FSM to IDLE, counters 0.
REQ-033 reset SHALL force cmd_valid 0, cmd_type NOP, cmd address 0, done_valid 0.
REQ-034 reset mid-operation SHALL abandon in-flight request without issuing further commands or done pulse.

Structure
REQ-035 Command enum, request struct (op, bg, ba, row, col), and timing defaults SHALL live in the shared definitions package.
REQ-036 Request buffer SHALL be a sub-module ddr5_req_fifo (depth-parameterised, push/pop/full/empty/count).

Verification
REQ-037 Read to closed bank 0/0 row 0x1234 col 0x10 -> ACT at t, RD at t+39, done_valid at t+39+48.
REQ-038 Second read same bank row 0x1234 after done -> RD issued next IDLE exit, no ACT/PRE.
REQ-039 Write to same bank row 0x5678 -> PRE, ACT 39 cycles later, WR 39 cycles after ACT, done 46 cycles after WR.
REQ-040 Push 17 requests back-to-back with FSM stalled -> 16 accepted, req_ready 0, q_count 16, 17th held.
REQ-041 Assert reset during WAIT_RCD -> next cycle cmd NOP, q_count 0, later request to same bank issues ACT (bank closed).
REQ-042 Simultaneous push and RW pop at q_count 5 -> q_count stays 5, order preserved.
